// File: rtl/ps2_key_ctrl.sv
// PS/2 scan-code sequencer: pops receiver FIFO bytes, tracks make/break/E0 and the held key.
// Optional feature macro: PS2_KEY_CTRL_EXT_EN (E0-prefixed keys tracked separately).
module ps2_key_ctrl (
    input  logic       i_clk,
    input  logic       i_clr,
    input  logic [7:0] i_ps2_data,
    input  logic       i_ps2_ready,
    input  logic       i_ps2_overflow,
    output logic       o_nextdata_n,
    output logic [7:0] o_key_code,
    output logic       o_key_ext,
    output logic       o_key_valid,
    output logic [7:0] o_key_count,
    output logic       o_err
);

    localparam logic [7:0] BYTE_BRK = 8'hF0;
    localparam logic [7:0] BYTE_EXT = 8'hE0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_POP  = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t     r_state;
    logic [7:0] r_byte;
    logic       r_nextdata_n;
    logic [7:0] r_key_code;
    logic       r_key_valid;
    logic [7:0] r_key_count;
    logic       r_err;
    logic       r_brk_pend;

    logic       w_ext_pend;
    logic       w_key_ext;
    logic       w_is_brk;
    logic       w_is_ext;
    logic       w_same_key;

`ifdef PS2_KEY_CTRL_EXT_EN
    logic       r_ext_pend;
    logic       r_key_ext;
    assign w_ext_pend = r_ext_pend;
    assign w_key_ext  = r_key_ext;
`else
    assign w_ext_pend = 1'b0;
    assign w_key_ext  = 1'b0;
`endif

    assign w_is_brk   = (r_byte == BYTE_BRK);
    assign w_is_ext   = (r_byte == BYTE_EXT);
    assign w_same_key = (r_byte == r_key_code) && (w_ext_pend == w_key_ext);

    // Pop handshake FSM with make/break decode in the POP cycle
    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_state      <= S_IDLE;
            r_byte       <= 8'h00;
            r_nextdata_n <= 1'b1;
            r_key_code   <= 8'h00;
            r_key_valid  <= 1'b0;
            r_key_count  <= 8'h00;
            r_err        <= 1'b0;
            r_brk_pend   <= 1'b0;
`ifdef PS2_KEY_CTRL_EXT_EN
            r_ext_pend   <= 1'b0;
            r_key_ext    <= 1'b0;
`endif
        end else begin
            if (i_ps2_overflow) begin
                r_err <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (i_ps2_ready) begin
                        r_byte       <= i_ps2_data;
                        r_nextdata_n <= 1'b0;
                        r_state      <= S_POP;
                    end
                end
                S_POP: begin
                    r_nextdata_n <= 1'b1;
                    r_state      <= S_GAP;
                    if (w_is_brk) begin
                        r_brk_pend <= 1'b1;
                    end else if (w_is_ext) begin
`ifdef PS2_KEY_CTRL_EXT_EN
                        r_ext_pend <= 1'b1;
`endif
                    end else if (r_brk_pend) begin
                        // Release only counts when it matches the key still held
                        if (r_key_valid && w_same_key) begin
                            r_key_valid <= 1'b0;
                        end
                        r_brk_pend <= 1'b0;
`ifdef PS2_KEY_CTRL_EXT_EN
                        r_ext_pend <= 1'b0;
`endif
                    end else begin
                        // New make; typematic repeats of the held key are dropped
                        if (!r_key_valid || !w_same_key) begin
                            r_key_code  <= r_byte;
                            r_key_valid <= 1'b1;
                            r_key_count <= r_key_count + 8'd1;
`ifdef PS2_KEY_CTRL_EXT_EN
                            r_key_ext   <= r_ext_pend;
`endif
                        end
`ifdef PS2_KEY_CTRL_EXT_EN
                        r_ext_pend <= 1'b0;
`endif
                    end
                end
                S_GAP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_nextdata_n = r_nextdata_n;
    assign o_key_code   = r_key_code;
    assign o_key_ext    = w_key_ext;
    assign o_key_valid  = r_key_valid;
    assign o_key_count  = r_key_count;
    assign o_err        = r_err;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Directed self-checking bench for ps2_key_ctrl; honours PS2_KEY_CTRL_EXT_EN if defined.
module tb_ps2_key_ctrl;

    logic       clk;
    logic       clr;
    logic [7:0] ps2_data;
    logic       ps2_ready;
    logic       ps2_overflow;
    logic       nextdata_n;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_valid;
    logic [7:0] key_count;
    logic       err;

    int total = 0;
    int bad   = 0;
    int pulses = 0;
    int dbl_low = 0;
    logic prev_low = 1'b0;

    ps2_key_ctrl dut (
        .i_clk          (clk),
        .i_clr          (clr),
        .i_ps2_data     (ps2_data),
        .i_ps2_ready    (ps2_ready),
        .i_ps2_overflow (ps2_overflow),
        .o_nextdata_n   (nextdata_n),
        .o_key_code     (key_code),
        .o_key_ext      (key_ext),
        .o_key_valid    (key_valid),
        .o_key_count    (key_count),
        .o_err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pop-strobe monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (nextdata_n === 1'b0) begin
            pulses <= pulses + 1;
            if (prev_low) dbl_low <= dbl_low + 1;
        end
        prev_low <= (nextdata_n === 1'b0);
    end

    // Present one byte while DUT is idle; returns #1 after the GAP edge
    task automatic send_byte(input logic [7:0] b);
        int n;
        ps2_data  = b;
        ps2_ready = 1'b1;
        n = 0;
        @(posedge clk); #1;
        while (nextdata_n !== 1'b0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (n != 0) begin
            bad++;
            $display("FAIL pop_latency byte=%02h extra_cycles=%0d required=0", b, n);
        end
        ps2_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic do_clear();
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
    endtask

    task automatic test_reset();
        do_clear();
        total++; if (nextdata_n !== 1'b1) begin bad++; $display("FAIL reset_nextdata got=%b exp=1", nextdata_n); end
        total++; if (key_code !== 8'h00) begin bad++; $display("FAIL reset_code got=%02h exp=00", key_code); end
        total++; if (key_ext !== 1'b0) begin bad++; $display("FAIL reset_ext got=%b exp=0", key_ext); end
        total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", key_valid); end
        total++; if (key_count !== 8'h00) begin bad++; $display("FAIL reset_count got=%0d exp=0", key_count); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
    endtask

    task automatic test_make_break();
        send_byte(8'h1C);
        total++; if (key_code !== 8'h1C) begin bad++; $display("FAIL make_code got=%02h exp=1C", key_code); end
        total++; if (key_valid !== 1'b1) begin bad++; $display("FAIL make_valid got=%b exp=1", key_valid); end
        total++; if (key_count !== 8'd1) begin bad++; $display("FAIL make_count got=%0d exp=1", key_count); end
        send_byte(8'hF0);
        total++; if (key_valid !== 1'b1) begin bad++; $display("FAIL brk_prefix_valid got=%b exp=1", key_valid); end
        send_byte(8'h1C);
        total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL release_valid got=%b exp=0", key_valid); end
        total++; if (key_code !== 8'h1C) begin bad++; $display("FAIL release_code got=%02h exp=1C", key_code); end
    endtask

    task automatic test_typematic();
        int p0;
        p0 = pulses;
        send_byte(8'h1C);
        send_byte(8'h1C);
        send_byte(8'h1C);
        total++; if (key_count !== 8'd2) begin bad++; $display("FAIL typematic_hold_count got=%0d exp=2", key_count); end
        send_byte(8'hF0);
        send_byte(8'h1C);
        total++; if (key_count !== 8'd2) begin bad++; $display("FAIL typematic_count got=%0d exp=2", key_count); end
        total++; if (pulses - p0 != 5) begin bad++; $display("FAIL typematic_pulses got=%0d exp=5", pulses - p0); end
        total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL typematic_valid got=%b exp=0", key_valid); end
    endtask

    task automatic test_rollover();
        send_byte(8'h1C);
        send_byte(8'h32);
        send_byte(8'hF0);
        send_byte(8'h1C);
        total++; if (key_code !== 8'h32) begin bad++; $display("FAIL rollover_code got=%02h exp=32", key_code); end
        total++; if (key_valid !== 1'b1) begin bad++; $display("FAIL rollover_valid got=%b exp=1", key_valid); end
        total++; if (key_count !== 8'd4) begin bad++; $display("FAIL rollover_count got=%0d exp=4", key_count); end
        send_byte(8'hF0);
        send_byte(8'h32);
        total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL rollover_release got=%b exp=0", key_valid); end
    endtask

    task automatic test_extended();
        send_byte(8'hE0);
        send_byte(8'h75);
        total++; if (key_code !== 8'h75) begin bad++; $display("FAIL ext_code got=%02h exp=75", key_code); end
        total++; if (key_count !== 8'd5) begin bad++; $display("FAIL ext_count got=%0d exp=5", key_count); end
`ifdef PS2_KEY_CTRL_EXT_EN
        total++; if (key_ext !== 1'b1) begin bad++; $display("FAIL ext_flag got=%b exp=1", key_ext); end
        send_byte(8'hF0);
        send_byte(8'h75);
        total++; if (key_valid !== 1'b1) begin bad++; $display("FAIL ext_mismatch_valid got=%b exp=1", key_valid); end
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL ext_release_valid got=%b exp=0", key_valid); end
`else
        total++; if (key_ext !== 1'b0) begin bad++; $display("FAIL ext_flag got=%b exp=0", key_ext); end
        send_byte(8'hF0);
        send_byte(8'h75);
        total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL noext_release_valid got=%b exp=0", key_valid); end
        send_byte(8'h75);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL noext_e0_release_valid got=%b exp=0", key_valid); end
        total++; if (key_count !== 8'd6) begin bad++; $display("FAIL noext_count got=%0d exp=6", key_count); end
`endif
    endtask

    task automatic test_wrap();
        logic [7:0] code;
        do_clear();
        for (int i = 0; i < 256; i++) begin
            code = 8'(i % 200) + 8'h01;
            send_byte(code);
            send_byte(8'hF0);
            send_byte(code);
            if (i == 254) begin
                total++; if (key_count !== 8'd255) begin bad++; $display("FAIL wrap_255 got=%0d exp=255", key_count); end
            end
        end
        total++; if (key_count !== 8'd0) begin bad++; $display("FAIL wrap_zero got=%0d exp=0", key_count); end
    endtask

    task automatic test_overflow();
        total++; if (err !== 1'b0) begin bad++; $display("FAIL err_pre got=%b exp=0", err); end
        ps2_overflow = 1'b1;
        @(posedge clk); #1;
        ps2_overflow = 1'b0;
        total++; if (err !== 1'b1) begin bad++; $display("FAIL err_rise got=%b exp=1", err); end
        send_byte(8'h4D);
        total++; if (err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", err); end
        total++; if (key_code !== 8'h4D || key_count !== 8'd1) begin
            bad++; $display("FAIL err_decode got=%02h/%0d exp=4D/1", key_code, key_count);
        end
    endtask

    task automatic test_mid_reset();
        int n;
        ps2_data  = 8'h1C;
        ps2_ready = 1'b1;
        n = 0;
        @(posedge clk); #1;
        while (nextdata_n !== 1'b0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        total++; if (n != 0) begin bad++; $display("FAIL midrst_pop got=%0d exp=0", n); end
        ps2_ready = 1'b0;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        total++; if (nextdata_n !== 1'b1) begin bad++; $display("FAIL midrst_nextdata got=%b exp=1", nextdata_n); end
        total++; if (key_code !== 8'h00 || key_valid !== 1'b0 || key_ext !== 1'b0) begin
            bad++; $display("FAIL midrst_key got=%02h/%b/%b exp=00/0/0", key_code, key_valid, key_ext);
        end
        total++; if (key_count !== 8'd0 || err !== 1'b0) begin
            bad++; $display("FAIL midrst_cnt_err got=%0d/%b exp=0/0", key_count, err);
        end
        send_byte(8'h29);
        total++; if (key_code !== 8'h29 || key_valid !== 1'b1) begin
            bad++; $display("FAIL midrst_next got=%02h/%b exp=29/1", key_code, key_valid);
        end
        total++; if (key_count !== 8'd1) begin bad++; $display("FAIL midrst_count got=%0d exp=1", key_count); end
    endtask

    task automatic test_back_to_back();
        total++; if (dbl_low != 0) begin bad++; $display("FAIL pop_double_low got=%0d exp=0", dbl_low); end
    endtask

    initial begin
        clr          = 1'b1;
        ps2_data     = 8'h00;
        ps2_ready    = 1'b0;
        ps2_overflow = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_make_break();
        test_typematic();
        test_rollover();
        test_extended();
        test_wrap();
        test_overflow();
        test_mid_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
